booth_row_drain_ctrl: RTL and testbench

Sequencer for one row of MATRIX_SIZE chained Booth PEs. On start it enables operand feed for MATRIX_SIZE cycles and waits out Booth pipeline plus row skew. It then drains the row's accumulated results through the rightmost PE's read_req/read_ready chain, one word per handshake, into a valid/ready output stream. Sits between the row and the array-level result collector.

---
 rtl/booth_row_drain_ctrl.sv | 92 +++++++++
 tb/tb_booth_row_drain_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_row_drain_ctrl.sv
// booth_row_drain_ctrl: feeds one Booth PE row, waits out pipeline skew, then drains its results as a stream
module booth_row_drain_ctrl #(
    parameter int MATRIX_SIZE  = 3,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = $clog2(MATRIX_SIZE*(2**INPUT_WIDTH))-1,
    parameter int PIPE_DEPTH   = 4,
    parameter int TIMEOUT      = 255,
    localparam int IW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    feed_en,
    output logic                    row_read_req,
    input  logic                    row_read_ready,
    input  logic [OUTPUT_WIDTH-1:0] row_data,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IW-1:0]           out_index,
    output logic                    out_last,
    output logic                    done,
    output logic                    error
);
    localparam int SETTLE_LEN = PIPE_DEPTH + MATRIX_SIZE - 1;
    localparam int CYC_MAX    = (SETTLE_LEN > MATRIX_SIZE) ? SETTLE_LEN : MATRIX_SIZE;
    localparam int CW         = $clog2(CYC_MAX + 1);
    localparam int TW         = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FEED, SETTLE, REQ, OUT, FIN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc;
    logic [TW-1:0] tmo;
    logic [IW-1:0] word;
    logic          last_word;

    assign last_word = word == IW'(MATRIX_SIZE - 1);
    assign out_index = word;
    assign out_last  = out_valid & last_word;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state: feed, settle, then one request/present round trip per word
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FEED : IDLE;
            FEED:    state_n = (cyc == CW'(MATRIX_SIZE - 1)) ? SETTLE : FEED;
            SETTLE:  state_n = (cyc == CW'(SETTLE_LEN - 1)) ? REQ : SETTLE;
            REQ:     state_n = row_read_ready ? OUT : (tmo == TW'(TIMEOUT - 1)) ? FIN : REQ;
            OUT:     state_n = !out_ready ? OUT : last_word ? FIN : REQ;
            default: state_n = IDLE;
        endcase
    end

    // counters, captured word, sticky error and registered control outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc          <= '0;
            tmo          <= '0;
            word         <= '0;
            out_data     <= '0;
            error        <= 1'b0;
            busy         <= 1'b0;
            feed_en      <= 1'b0;
            row_read_req <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            cyc          <= (state_n == state && (state == FEED || state == SETTLE)) ? cyc + 1'b1 : '0;
            tmo          <= (state == REQ && state_n == REQ) ? tmo + 1'b1 : '0;
            busy         <= state_n != IDLE;
            feed_en      <= state_n == FEED;
            row_read_req <= state_n == REQ;
            out_valid    <= state_n == OUT;
            done         <= state_n == FIN;
            if (state == IDLE && start) begin
                word  <= '0;
                error <= 1'b0;
            end
            if (state == REQ && row_read_ready) out_data <= row_data;
            if (state == REQ && state_n == FIN) error <= 1'b1;
            if (state == OUT && out_ready && !last_word) word <= word + 1'b1;
        end
    end
endmodule

// File: tb/tb_booth_row_drain_ctrl.sv
// tb_booth_row_drain_ctrl: directed scenario bench for the row drain sequencer
module tb_booth_row_drain_ctrl;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, row_read_ready = 1'b0, out_ready = 1'b0;
    logic [8:0] row_data = '0;
    logic       busy, feed_en, row_read_req, out_valid, out_last, done, error;
    logic [8:0] out_data;
    logic [1:0] out_index;
    logic       start4 = 1'b0;
    logic       busy4, feed_en4, row_read_req4, out_valid4, out_last4, done4, error4;
    logic [8:0] out_data4;
    logic [1:0] out_index4;
    int         checks = 0, passes = 0;
    logic [8:0] nom_words [3] = '{9'h005, 9'h1FE, 9'h0A0};
    logic [8:0] ign_words [3] = '{9'h011, 9'h022, 9'h033};

    // free-running clock
    always #5 clk = ~clk;

    booth_row_drain_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .feed_en(feed_en),
        .row_read_req(row_read_req), .row_read_ready(row_read_ready), .row_data(row_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_last(out_last), .done(done), .error(error)
    );

    booth_row_drain_ctrl #(.MATRIX_SIZE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .busy(busy4), .feed_en(feed_en4),
        .row_read_req(row_read_req4), .row_read_ready(1'b0), .row_data(9'h000),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(1'b0), .out_index(out_index4),
        .out_last(out_last4), .done(done4), .error(error4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // wait for a request, answer one cycle later; returns with the word presented on the output
    task automatic serve(input logic [8:0] d, output bit to);
        int n;
        n = 0;
        while (!row_read_req && n < 400) begin
            step();
            n++;
        end
        to = !row_read_req;
        step();
        row_read_ready = 1'b1;
        row_data = d;
        step();
        row_read_ready = 1'b0;
        row_data = 9'h1AA;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        checks++; if ({busy, feed_en, row_read_req, out_valid, out_last, done, error} !== 7'b0) $display("FAIL rst_ctrl: got %b want 0000000", {busy, feed_en, row_read_req, out_valid, out_last, done, error}); else passes++;
        checks++; if ({out_index, out_data} !== 11'h0) $display("FAIL rst_data: got %h want 000", {out_index, out_data}); else passes++;
        reset = 1'b0;
        repeat (2) step();
        checks++; if (busy !== 1'b0) $display("FAIL rst_idle: busy=%b want 0", busy); else passes++;
    endtask

    task automatic test_nominal();
        int n, f;
        bit to;
        out_ready = 1'b1;
        start_job();
        n = 1;
        f = int'(feed_en);
        while (!row_read_req && n < 40) begin
            step();
            n++;
            f += int'(feed_en);
        end
        checks++; if (n != 10) $display("FAIL nom_latency: got %0d want 10", n); else passes++;
        checks++; if (f != 3) $display("FAIL nom_feed: got %0d want 3", f); else passes++;
        for (int i = 0; i < 3; i++) begin
            serve(nom_words[i], to);
            checks++; if (to || out_valid !== 1'b1 || row_read_req !== 1'b0) $display("FAIL nom_hs%0d: to=%0d valid=%b req=%b want 0 1 0", i, to, out_valid, row_read_req); else passes++;
            checks++; if (out_data !== nom_words[i]) $display("FAIL nom_data%0d: got %h want %h", i, out_data, nom_words[i]); else passes++;
            checks++; if (out_index !== 2'(i) || out_last !== (i == 2)) $display("FAIL nom_idx%0d: idx=%0d last=%b want %0d %b", i, out_index, out_last, i, i == 2); else passes++;
            step();
        end
        checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL nom_done: done=%b error=%b want 1 0", done, error); else passes++;
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL nom_idle: done=%b busy=%b want 0 0", done, busy); else passes++;
    endtask

    task automatic test_ignored();
        int n, f;
        bit to;
        out_ready = 1'b1;
        start_job();
        n = 1;
        f = int'(feed_en);
        while (!row_read_req && n < 40) begin
            start = feed_en;
            row_read_ready = (n == 5);
            row_data = 9'h0AA;
            step();
            n++;
            f += int'(feed_en);
        end
        start = 1'b0;
        row_read_ready = 1'b0;
        checks++; if (n != 10 || f != 3) $display("FAIL ign_timing: lat=%0d feed=%0d want 10 3", n, f); else passes++;
        checks++; if (out_data !== 9'h0A0 || out_valid !== 1'b0) $display("FAIL ign_nocapture: data=%h valid=%b want 0a0 0", out_data, out_valid); else passes++;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve(ign_words[i], to);
            checks++; if (to || out_data !== ign_words[i] || out_index !== 2'(i)) $display("FAIL ign_word%0d: to=%0d data=%h idx=%0d want 0 %h %0d", i, to, out_data, out_index, ign_words[i], i); else passes++;
            step();
        end
        checks++; if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done); else passes++;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL ign_fin_start: busy=%b want 0", busy); else passes++;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL ign_idle: busy=%b want 0", busy); else passes++;
    endtask

    task automatic test_backpressure();
        bit to, ok;
        out_ready = 1'b1;
        start_job();
        serve(9'h077, to);
        step();
        out_ready = 1'b0;
        serve(9'h1FE, to);
        checks++; if (to || out_valid !== 1'b1 || out_data !== 9'h1FE) $display("FAIL bp_w1: valid=%b data=%h want 1 1fe", out_valid, out_data); else passes++;
        ok = 1'b1;
        repeat (5) begin
            row_read_ready = 1'b1;
            row_data = 9'h055;
            step();
            if (out_valid !== 1'b1 || out_data !== 9'h1FE || row_read_req !== 1'b0 || out_index !== 2'd1) ok = 1'b0;
        end
        row_read_ready = 1'b0;
        checks++; if (!ok) $display("FAIL bp_hold: held=%b want 1", ok); else passes++;
        out_ready = 1'b1;
        step();
        checks++; if (row_read_req !== 1'b1 || out_valid !== 1'b0 || out_index !== 2'd2) $display("FAIL bp_resume: req=%b valid=%b idx=%0d want 1 0 2", row_read_req, out_valid, out_index); else passes++;
        serve(9'h0A0, to);
        checks++; if (to || out_data !== 9'h0A0 || out_last !== 1'b1) $display("FAIL bp_last: data=%h last=%b want 0a0 1", out_data, out_last); else passes++;
        step();
        checks++; if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done); else passes++;
        step();
    endtask

    task automatic test_timeout();
        int c;
        bit to;
        out_ready = 1'b1;
        start_job();
        serve(9'h101, to);
        step();
        serve(9'h102, to);
        step();
        c = 0;
        while (row_read_req && c < 400) begin
            c++;
            step();
        end
        checks++; if (c != 255) $display("FAIL to_cycles: got %0d want 255", c); else passes++;
        checks++; if (done !== 1'b1 || error !== 1'b1 || row_read_req !== 1'b0) $display("FAIL to_fin: done=%b err=%b req=%b want 1 1 0", done, error, row_read_req); else passes++;
        step();
        checks++; if (done !== 1'b0 || error !== 1'b1 || busy !== 1'b0) $display("FAIL to_sticky: done=%b err=%b busy=%b want 0 1 0", done, error, busy); else passes++;
        start_job();
        checks++; if (error !== 1'b0 || feed_en !== 1'b1) $display("FAIL to_clear: err=%b feed=%b want 0 1", error, feed_en); else passes++;
        serve(9'h1C3, to);
        checks++; if (to || out_index !== 2'd0 || out_data !== 9'h1C3) $display("FAIL to_restart: idx=%0d data=%h want 0 1c3", out_index, out_data); else passes++;
        step();
        repeat (2) begin
            serve(9'h003, to);
            step();
        end
        checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL to_rerun: done=%b err=%b want 1 0", done, error); else passes++;
        step();
    endtask

    task automatic test_async_reset();
        bit to;
        logic d;
        out_ready = 1'b1;
        start_job();
        serve(9'h0F0, to);
        checks++; if (to || out_valid !== 1'b1) $display("FAIL ar_pre: valid=%b want 1", out_valid); else passes++;
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, feed_en, row_read_req, out_valid, out_last, done, error, out_index, out_data} !== 18'h0) $display("FAIL ar_clear: got %h want 0", {busy, feed_en, row_read_req, out_valid, out_last, done, error, out_index, out_data}); else passes++;
        d = 1'b0;
        repeat (2) begin
            step();
            d |= done;
        end
        reset = 1'b0;
        repeat (2) begin
            step();
            d |= done | busy;
        end
        checks++; if (d !== 1'b0) $display("FAIL ar_nodone: got %b want 0", d); else passes++;
        start_job();
        for (int i = 0; i < 3; i++) begin
            serve(nom_words[i], to);
            checks++; if (to || out_data !== nom_words[i] || out_index !== 2'(i)) $display("FAIL ar_word%0d: data=%h idx=%0d want %h %0d", i, out_data, out_index, nom_words[i], i); else passes++;
            step();
        end
        checks++; if (done !== 1'b1) $display("FAIL ar_done: got %b want 1", done); else passes++;
        step();
    endtask

    task automatic test_latency4();
        int n, f, s;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        n = 1;
        f = int'(feed_en4);
        s = 0;
        while (!row_read_req4 && n < 40) begin
            step();
            n++;
            f += int'(feed_en4);
            s += int'(busy4 && !feed_en4 && !row_read_req4);
        end
        checks++; if (f != 4) $display("FAIL l4_feed: got %0d want 4", f); else passes++;
        checks++; if (s != 7) $display("FAIL l4_settle: got %0d want 7", s); else passes++;
        checks++; if (n != 12) $display("FAIL l4_latency: got %0d want 12", n); else passes++;
    endtask

    // scenario sequence and summary
    initial begin
        test_reset();
        test_nominal();
        test_ignored();
        test_backpressure();
        test_timeout();
        test_async_reset();
        test_latency4();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // run-length guard
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
        $fatal(1);
    end
endmodule
